// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants for the data-memory responder and its timer
package dmem_pkg;
   localparam int          DEFAULT_DEPTH = 64;
   localparam logic [15:0] MMIO_BASE     = 16'hFFFF;
   localparam logic [15:0] OFF_CNT       = 16'h0000;
   localparam logic [15:0] OFF_CMP       = 16'h0004;
   localparam logic [15:0] OFF_CTRL      = 16'h0008;
   localparam logic [15:0] OFF_STATUS    = 16'h000C;
   localparam int          CTRL_EN       = 0;
   localparam int          CTRL_AUTOCLR  = 1;
   localparam int          ST_MATCH      = 0;
   localparam int          ST_ERR        = 1;
endpackage

// File: rtl/dmem_timer.sv
// dmem_timer: free-running CNT with CMP match detection and optional auto-clear
module dmem_timer
   import dmem_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        we_cnt_i,
   input  logic        we_cmp_i,
   input  logic        we_ctrl_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] cnt_o,
   output logic [31:0] cmp_o,
   output logic [1:0]  ctrl_o,
   output logic        match_o
);
   logic [31:0] cnt_q, cnt_d, cmp_q, cmp_d;
   logic [1:0]  ctrl_q, ctrl_d;
   logic        hit;
   // next state: a software write to CNT beats both auto-clear and increment
   always_comb begin
      hit    = ctrl_q[CTRL_EN] && (cnt_q == cmp_q);
      cnt_d  = we_cnt_i ? wdata_i :
               (hit && ctrl_q[CTRL_AUTOCLR]) ? '0 :
               ctrl_q[CTRL_EN] ? cnt_q + 32'd1 : cnt_q;
      cmp_d  = we_cmp_i ? wdata_i : cmp_q;
      ctrl_d = we_ctrl_i ? wdata_i[1:0] : ctrl_q;
   end
   // timer registers
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         cmp_q  <= '0;
         ctrl_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         cmp_q  <= cmp_d;
         ctrl_q <= ctrl_d;
      end
   end
   assign cnt_o   = cnt_q;
   assign cmp_o   = cmp_q;
   assign ctrl_o  = ctrl_q;
   assign match_o = hit;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: zero-latency RAM plus MMIO STATUS and timer; timer built only with DMEM_TIMER_EN
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] memaddr,
   input  logic [31:0] memwritedata,
   output logic [31:0] memreaddata,
   output logic        timer_irq,
   output logic        bus_err
);
   logic [31:0]   mem_q [DEPTH];
   logic [AW-1:0] idx;
   logic [15:0]   off;
   logic          mmio, mis, wr;
   logic [31:0]   t_cnt, t_cmp;
   logic [1:0]    t_ctrl, st_q, st_d, set, w1c;
   logic          t_match;
   assign idx  = memaddr[AW+1:2];
   assign off  = memaddr[15:0];
   assign mmio = memaddr[31:16] == MMIO_BASE;
   assign mis  = memaddr[1:0] != 2'b00;
   assign wr   = memwrite && !reset && !mis;
`ifdef DMEM_TIMER_EN
   dmem_timer u_timer (
      .clk      (clk),
      .reset    (reset),
      .we_cnt_i (wr && mmio && off == OFF_CNT),
      .we_cmp_i (wr && mmio && off == OFF_CMP),
      .we_ctrl_i(wr && mmio && off == OFF_CTRL),
      .wdata_i  (memwritedata),
      .cnt_o    (t_cnt),
      .cmp_o    (t_cmp),
      .ctrl_o   (t_ctrl),
      .match_o  (t_match)
   );
`else
   assign t_cnt   = '0;
   assign t_cmp   = '0;
   assign t_ctrl  = '0;
   assign t_match = 1'b0;
`endif
   // RAM write port; contents survive reset
   always_ff @(posedge clk) begin
      if (wr && !mmio) mem_q[idx] <= memwritedata;
   end
   // STATUS next state: new set events override a coincident write-1-to-clear
   always_comb begin
      set           = '0;
      set[ST_MATCH] = t_match;
      set[ST_ERR]   = mis;
      w1c           = (wr && mmio && off == OFF_STATUS) ? memwritedata[1:0] : 2'b00;
      st_d          = (st_q & ~w1c) | set;
   end
   // STATUS register
   always_ff @(posedge clk) begin
      if (reset) st_q <= '0;
      else st_q <= st_d;
   end
   // read mux: misaligned reads return 0, unmapped MMIO returns 0
   always_comb begin
      memreaddata = mis ? '0 :
                    !mmio ? mem_q[idx] :
                    off == OFF_CNT ? t_cnt :
                    off == OFF_CMP ? t_cmp :
                    off == OFF_CTRL ? {30'b0, t_ctrl} :
                    off == OFF_STATUS ? {30'b0, st_q} : '0;
   end
   assign timer_irq = st_q[ST_MATCH];
   assign bus_err   = st_q[ST_ERR];
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder (both DMEM_TIMER_EN builds)
module tb_dmem_responder;
   localparam logic [31:0] A_CNT = 32'hFFFF0000;
   localparam logic [31:0] A_CMP = 32'hFFFF0004;
   localparam logic [31:0] A_CTRL = 32'hFFFF0008;
   localparam logic [31:0] A_ST = 32'hFFFF000C;
   localparam int NO = -1, RD = 0, IRQ = 1, ERR = 2;
   typedef struct {
      int          k;
      logic [31:0] e;
      string       n;
   } exp_t;
   logic        clk = 0, reset = 1, memwrite = 0, timer_irq, bus_err;
   logic [31:0] memaddr = 0, memwritedata = 0, memreaddata;
   logic        chk = 0;
   exp_t        q[$];
   int          n_chk = 0, n_fail = 0;
   dmem_responder dut (
      .clk         (clk),
      .reset       (reset),
      .memwrite    (memwrite),
      .memaddr     (memaddr),
      .memwritedata(memwritedata),
      .memreaddata (memreaddata),
      .timer_irq   (timer_irq),
      .bus_err     (bus_err)
   );
   always #5 clk = ~clk;
   task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input int k, input logic [31:0] e, input string n);
      exp_t x;
      @(posedge clk);
      #1;
      reset = r;
      memwrite = w;
      memaddr = a;
      memwritedata = d;
      chk = k >= 0;
      if (k >= 0) begin
         x.k = k;
         x.e = e;
         x.n = n;
         q.push_back(x);
      end
   endtask
   always @(negedge clk) begin
      exp_t x;
      logic [31:0] act;
      if (chk) begin
         n_chk++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty at %0t", $time);
         end else begin
            x = q.pop_front();
            act = x.k == RD ? memreaddata : x.k == IRQ ? {31'b0, timer_irq} : {31'b0, bus_err};
            if (act !== x.e) begin
               n_fail++;
               $display("FAIL %s: got %h expected %h", x.n, act, x.e);
            end
         end
      end
   end
   initial begin
      step(1, 0, 0, 0, NO, 0, "");
      step(1, 0, 0, 0, NO, 0, "");
      step(0, 0, 0, 0, IRQ, 0, "irq_rst");
      step(0, 0, 0, 0, ERR, 0, "err_rst");
      step(0, 0, A_ST, 0, RD, 0, "status_rst");
      step(0, 1, 32'h20, 32'h11111111, NO, 0, "");
      step(1, 1, 32'h20, 32'h22222222, NO, 0, "");
      step(0, 0, 32'h20, 0, RD, 32'h11111111, "ram_wr_in_rst");
      step(0, 1, 32'h10, 32'hCAFEF00D, NO, 0, "");
      step(0, 1, 32'h10, 32'hDEADBEEF, RD, 32'hCAFEF00D, "ram_old");
      step(0, 0, 32'h10, 0, RD, 32'hDEADBEEF, "ram_new");
      step(0, 0, 32'h110, 0, RD, 32'hDEADBEEF, "ram_alias");
      step(0, 1, 32'h13, 32'h12345678, RD, 0, "mis_rd");
      step(0, 0, 32'h10, 0, ERR, 1, "err_set");
      step(0, 0, 32'h10, 0, RD, 32'hDEADBEEF, "mis_nowr");
      step(0, 0, A_ST, 0, RD, 2, "status_err");
      step(0, 1, A_ST, 2, NO, 0, "");
      step(0, 0, A_ST, 0, ERR, 0, "err_w1c");
      step(0, 1, 32'hFFFF0020, 32'h5, RD, 0, "mmio_unmapped");
`ifdef DMEM_TIMER_EN
      step(0, 1, A_CMP, 5, NO, 0, "");
      step(0, 1, A_CNT, 0, NO, 0, "");
      step(0, 0, A_CMP, 0, RD, 5, "cmp_rb");
      step(0, 1, A_CTRL, 3, NO, 0, "");
      for (int i = 0; i < 6; i++) step(0, 0, A_CNT, 0, RD, i, "cnt_run");
      step(0, 0, A_CNT, 0, RD, 0, "cnt_autoclr");
      step(0, 0, A_CNT, 0, IRQ, 1, "irq_match");
      step(0, 1, A_ST, 1, NO, 0, "");
      step(0, 0, A_CNT, 0, IRQ, 0, "irq_w1c");
      step(0, 1, A_CTRL, 0, NO, 0, "");
      step(0, 1, A_CTRL, 3, NO, 0, "");
      step(0, 1, A_CNT, 32'h100, NO, 0, "");
      step(0, 0, A_CNT, 0, RD, 32'h100, "cnt_prio");
      step(0, 0, A_CNT, 0, IRQ, 1, "irq_prio");
      step(0, 1, A_CMP, 32'h105, NO, 0, "");
      step(0, 0, A_CNT, 0, RD, 32'h103, "cnt_inc");
      step(0, 0, A_CNT, 0, NO, 0, "");
      step(0, 1, A_ST, 1, NO, 0, "");
      step(0, 0, A_CNT, 0, IRQ, 1, "irq_set_wins");
      step(0, 1, A_CTRL, 0, NO, 0, "");
      step(0, 1, A_CNT, 32'hFFFFFFFF, NO, 0, "");
      step(0, 1, A_CTRL, 1, NO, 0, "");
      step(0, 0, A_CNT, 0, RD, 32'hFFFFFFFF, "cnt_max");
      step(0, 0, A_CNT, 0, RD, 0, "cnt_wrap");
      step(0, 0, A_CNT, 0, IRQ, 1, "irq_pre_rst");
`else
      step(0, 1, A_CNT, 32'h1234, NO, 0, "");
      step(0, 0, A_CNT, 0, RD, 0, "cnt_absent");
      step(0, 1, A_CMP, 0, NO, 0, "");
      step(0, 1, A_CTRL, 3, NO, 0, "");
      for (int i = 0; i < 3; i++) step(0, 0, A_CNT, 0, IRQ, 0, "irq_tied");
      step(0, 0, A_CTRL, 0, RD, 0, "ctrl_absent");
`endif
      step(0, 0, 32'h2, 0, NO, 0, "");
      step(1, 0, 32'h10, 0, NO, 0, "");
`ifdef DMEM_TIMER_EN
      step(0, 0, A_CNT, 0, RD, 0, "cnt_rst");
      step(0, 0, A_CNT, 0, RD, 0, "cnt_hold");
      step(0, 0, A_CTRL, 0, RD, 0, "ctrl_rst");
`endif
      step(0, 0, A_CNT, 0, IRQ, 0, "irq_mid_rst");
      step(0, 0, A_CNT, 0, ERR, 0, "err_mid_rst");
      step(0, 0, 32'h10, 0, RD, 32'hDEADBEEF, "ram_keep");
      step(0, 0, 0, 0, NO, 0, "");
      @(posedge clk);
      #1;
      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
